// File: rtl/dff_mux_ctrl_pkg.sv
// Shared types for the mux-DFF sequencer: FSM states, requester id and the
// settle-counter width.
package dff_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CHECK, RESP, CLR, CLRCHK} state_t;
    typedef logic req_id_t;
    localparam int SETTLE_MAX = 15;
    localparam int CNT_W      = $clog2(SETTLE_MAX + 1);
endpackage

// File: rtl/dff_mux_ctrl_if.sv
// Requester-side handshake plus the drive/readback wires of the shared mux-DFF.
interface dff_mux_ctrl_if #(parameter int ERR_W = 4);
    logic             req0, data0, req1, data1, clr_req;
    logic             gnt0, gnt1, ack, ack_id, ack_data, clr_done, err;
    logic [ERR_W-1:0] err_cnt;
    logic             dff_rst, dff_sel, dff_d0, dff_d1, dff_q;

    modport slave (
        input  req0, data0, req1, data1, clr_req, dff_q,
        output gnt0, gnt1, ack, ack_id, ack_data, clr_done, err, err_cnt,
               dff_rst, dff_sel, dff_d0, dff_d1
    );
    modport master (
        output req0, data0, req1, data1, clr_req, dff_q,
        input  gnt0, gnt1, ack, ack_id, ack_data, clr_done, err, err_cnt,
               dff_rst, dff_sel, dff_d0, dff_d1
    );
endinterface

// File: rtl/dff_mux_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the favoured requester and
// moves to the other one only when the grant is actually taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = req;
        ptr_d = ptr_q;
        if (req == 2'b11) begin
            gnt        = 2'b00;
            gnt[ptr_q] = 1'b1;
        end
        if (take && (gnt != 2'b00))
            ptr_d = ~gnt[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/dff_mux_ctrl.sv
// Shares one 2:1-mux DFF between two writers and a clear source: grants a write,
// drives sel/legs, waits for capture + SETTLE, reads q back and flags mismatches.
module dff_mux_ctrl
    import dff_ctrl_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int ERR_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    dff_mux_ctrl_if.slave  bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_id_t          id_q, id_d, ack_id_q, ack_id_d;
    logic             data_q, data_d, qs_q, qs_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d, ack_q, ack_d;
    logic             ack_data_q, ack_data_d, clr_done_q, clr_done_d, err_q, err_d;
    logic             dff_rst_q, dff_rst_d, sel_q, sel_d, d0_q, d0_d, d1_q, d1_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]       arb_gnt;
    logic             take;

    assign take = (state_q == IDLE) && !bus.clr_req && (arb_gnt != 2'b00);

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({bus.req1, bus.req0}),
        .take (take),
        .gnt  (arb_gnt)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        data_d     = data_q;
        qs_d       = qs_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        ack_d      = 1'b0;
        ack_id_d   = ack_id_q;
        ack_data_d = ack_data_q;
        clr_done_d = 1'b0;
        err_d      = 1'b0;
        dff_rst_d  = 1'b0;
        sel_d      = sel_q;
        d0_d       = d0_q;
        d1_d       = d1_q;
        err_cnt_d  = err_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    dff_rst_d = 1'b1;
                    state_d   = CLR;
                end else if (take) begin
                    id_d   = arb_gnt[1];
                    data_d = arb_gnt[1] ? bus.data1 : bus.data0;
                    gnt0_d = arb_gnt[0];
                    gnt1_d = arb_gnt[1];
                    // Unselected leg carries the inverse so a wrong select shows up in q.
                    sel_d  = arb_gnt[1];
                    d0_d   = arb_gnt[1] ? ~bus.data1 : bus.data0;
                    d1_d   = arb_gnt[1] ? bus.data1 : ~bus.data0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = CNT_W'(SETTLE);
                state_d = (SETTLE == 0) ? CHECK : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = CHECK;
            end
            CHECK: begin
                qs_d    = bus.dff_q;
                state_d = RESP;
            end
            RESP: begin
                ack_d      = 1'b1;
                ack_id_d   = id_q;
                ack_data_d = qs_q;
                err_d      = (qs_q !== data_q);
                state_d    = IDLE;
            end
            CLR: state_d = CLRCHK;
            CLRCHK: begin
                clr_done_d = 1'b1;
                err_d      = (bus.dff_q !== 1'b0);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (err_d && (err_cnt_q != {ERR_W{1'b1}}))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            id_q       <= 1'b0;
            data_q     <= 1'b0;
            qs_q       <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            ack_q      <= 1'b0;
            ack_id_q   <= 1'b0;
            ack_data_q <= 1'b0;
            clr_done_q <= 1'b0;
            err_q      <= 1'b0;
            dff_rst_q  <= 1'b0;
            sel_q      <= 1'b0;
            d0_q       <= 1'b0;
            d1_q       <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            data_q     <= data_d;
            qs_q       <= qs_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            ack_q      <= ack_d;
            ack_id_q   <= ack_id_d;
            ack_data_q <= ack_data_d;
            clr_done_q <= clr_done_d;
            err_q      <= err_d;
            dff_rst_q  <= dff_rst_d;
            sel_q      <= sel_d;
            d0_q       <= d0_d;
            d1_q       <= d1_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.ack      = ack_q;
    assign bus.ack_id   = ack_id_q;
    assign bus.ack_data = ack_data_q;
    assign bus.clr_done = clr_done_q;
    assign bus.err      = err_q;
    assign bus.err_cnt  = err_cnt_q;
    // The DFF is cleared together with the controller.
    assign bus.dff_rst  = rst | dff_rst_q;
    assign bus.dff_sel  = sel_q;
    assign bus.dff_d0   = d0_q;
    assign bus.dff_d1   = d1_q;
endmodule

// File: tb/tb_dff_mux_ctrl.sv
// Bench for dff_mux_ctrl: vector table, directed corner sequences, and a random
// phase scored against a transaction-level timing model.
module tb_dff_mux_ctrl;
    localparam int S  = 1;
    localparam int EW = 4;
    localparam int N  = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   fault = 1'b0;
    logic q;
    int   nchk = 0, nerr = 0;

    dff_mux_ctrl_if #(.ERR_W(EW)) bus ();
    dff_mux_ctrl #(.SETTLE(S), .ERR_W(EW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // Shared mux-DFF; the fault mode pins the select to the d0 leg.
    always @(posedge clk) begin
        if (bus.dff_rst) q <= 1'b0;
        else             q <= fault ? bus.dff_d0 : (bus.dff_sel ? bus.dff_d1 : bus.dff_d0);
    end
    assign bus.dff_q = q;

    typedef struct {
        logic r0, d0, r1, d1;
        logic [1:0] g;     // {gnt1,gnt0}
        logic [2:0] sdd;   // {sel,d0,d1}
        logic [2:0] resp;  // {ack_id,ack_data,err}
    } vec_t;

    typedef struct {
        logic [1:0] g;
        logic [2:0] sdd;
        logic       ack, ai, ad, cd, dr;
    } exp_t;

    vec_t vecs[7];
    exp_t e[N+8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic xact(input logic r0, d0, r1, d1,
                        output logic [1:0] g, output logic [2:0] sdd, output logic [2:0] resp);
        bit got = 1'b0;
        bus.req0 = r0; bus.data0 = d0; bus.req1 = r1; bus.data1 = d1;
        g = 2'b00; sdd = 3'bxxx; resp = 3'bxxx;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            got = bus.gnt0 | bus.gnt1;
        end
        chk("gnt_wait", 32'(got), 32'd1);
        if (got) begin
            g   = {bus.gnt1, bus.gnt0};
            sdd = {bus.dff_sel, bus.dff_d0, bus.dff_d1};
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            step(2 + S);
            chk("ack_early", 32'(bus.ack), 32'd0);
            step();
            chk("ack_latency", 32'(bus.ack), 32'd1);
            resp = {bus.ack_id, bus.ack_data, bus.err};
        end
    endtask

    initial begin
        #100000;
        nerr++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        logic [1:0] g;
        logic [2:0] sdd, resp;
        bit got;
        logic r0, d0, r1, d1, cr, last, id, dat;
        int free_at;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'b010, 3'b010};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'b110, 3'b100};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 3'b101, 3'b110};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 3'b001, 3'b000};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 3'b101, 3'b110};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'b001, 3'b000};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 3'b110, 3'b100};

        bus.req0 = 1'b0; bus.data0 = 1'b0; bus.req1 = 1'b0; bus.data1 = 1'b0; bus.clr_req = 1'b0;

        // Reset state, then a lone clear.
        rst = 1'b1;
        step(3);
        chk("rst_outs", 32'({bus.gnt0, bus.gnt1, bus.ack, bus.ack_id, bus.ack_data, bus.clr_done,
                             bus.err, bus.dff_sel, bus.dff_d0, bus.dff_d1}), 32'd0);
        chk("rst_errcnt", 32'(bus.err_cnt), 32'd0);
        chk("rst_dffrst", 32'(bus.dff_rst), 32'd1);
        rst = 1'b0;
        bus.clr_req = 1'b1;
        step(); chk("clr_rst_on", 32'(bus.dff_rst), 32'd1);
        step(); chk("clr_rst_off", 32'({bus.dff_rst, bus.clr_done}), 32'd0);
        step(); chk("clr_done", 32'({bus.clr_done, bus.err, bus.dff_q}), 32'b100);
        bus.clr_req = 1'b0;
        step(); chk("clr_done_pulse", 32'(bus.clr_done), 32'd0);

        // Vector table: single and contending writes through the round-robin.
        for (int i = 0; i < 7; i++) begin
            xact(vecs[i].r0, vecs[i].d0, vecs[i].r1, vecs[i].d1, g, sdd, resp);
            chk($sformatf("vec%0d_gnt", i), 32'(g), 32'(vecs[i].g));
            chk($sformatf("vec%0d_legs", i), 32'(sdd), 32'(vecs[i].sdd));
            chk($sformatf("vec%0d_resp", i), 32'(resp), 32'(vecs[i].resp));
        end

        // Both requesters held: grants alternate.
        bus.req0 = 1'b1; bus.data0 = 1'b0; bus.req1 = 1'b1; bus.data1 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            got = 1'b0;
            for (int i = 0; i < 12 && !got; i++) begin
                step();
                got = bus.gnt0 | bus.gnt1;
            end
            chk("alt_gnt", 32'({bus.gnt1, bus.gnt0}), (n % 2 == 1) ? 32'b10 : 32'b01);
            if (n == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
            step(3 + S);
            chk("alt_ack", 32'({bus.ack, bus.ack_id, bus.ack_data}),
                (n % 2 == 1) ? 32'b111 : 32'b100);
        end

        // Clear and req1 rise together: clear first, then the write.
        xact(1'b1, 1'b1, 1'b0, 1'b0, g, sdd, resp);
        chk("pre_clr_q", 32'(bus.dff_q), 32'd1);
        bus.clr_req = 1'b1; bus.req1 = 1'b1; bus.data1 = 1'b0;
        step(); chk("c5_clr_first", 32'({bus.dff_rst, bus.gnt1}), 32'b10);
        step(); chk("c5_rst_1cyc", 32'(bus.dff_rst), 32'd0);
        step(); chk("c5_clr_done", 32'({bus.clr_done, bus.err}), 32'b10);
        bus.clr_req = 1'b0;
        step(); chk("c5_gnt1", 32'({bus.gnt1, bus.gnt0}), 32'b10);
        bus.req1 = 1'b0;
        step(3 + S); chk("c5_ack", 32'({bus.ack, bus.ack_id, bus.ack_data, bus.err}), 32'b1100);

        // Select stuck at d0: every d1 write mismatches, counter saturates.
        fault = 1'b1;
        xact(1'b0, 1'b0, 1'b1, 1'b1, g, sdd, resp);
        chk("flt_resp", 32'(resp), 32'b101);
        step(); chk("flt_cnt1", 32'(bus.err_cnt), 32'd1);
        for (int i = 0; i < 16; i++) xact(1'b0, 1'b0, 1'b1, 1'b1, g, sdd, resp);
        step(); chk("flt_sat", 32'(bus.err_cnt), 32'd15);
        fault = 1'b0;

        // Reset during WAIT aborts the write.
        bus.req0 = 1'b1; bus.data0 = 1'b1;
        step(); chk("e_gnt", 32'(bus.gnt0), 32'd1);
        bus.req0 = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("e_outs", 32'({bus.gnt0, bus.gnt1, bus.ack, bus.ack_id, bus.ack_data, bus.clr_done,
                           bus.err, bus.dff_sel, bus.dff_d0, bus.dff_d1, bus.err_cnt}), 32'd0);
        chk("e_dffrst", 32'(bus.dff_rst), 32'd1);
        for (int i = 0; i < 3; i++) begin step(); chk("e_no_ack_rst", 32'(bus.ack), 32'd0); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); chk("e_no_ack", 32'({bus.ack, bus.gnt0, bus.gnt1, bus.clr_done}), 32'd0);
        end
        xact(1'b1, 1'b0, 1'b1, 1'b1, g, sdd, resp);
        chk("e_regnt", 32'(g), 32'b01);
        chk("e_resp", 32'(resp), 32'b000);

        // Random traffic against the transaction timing model.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        for (int k = 0; k < N + 8; k++) e[k] = '{2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        r0 = 1'b0; d0 = 1'b0; r1 = 1'b0; d1 = 1'b0; cr = 1'b0;
        last = 1'b1; free_at = 0;
        bus.req0 = r0; bus.data0 = d0; bus.req1 = r1; bus.data1 = d1; bus.clr_req = cr;
        for (int k = 0; k < N; k++) begin
            step();
            if (k >= free_at) begin
                if (cr) begin
                    e[k].dr = 1'b1;
                    e[k+2].cd = 1'b1;
                    free_at = k + 3;
                end else if (r0 | r1) begin
                    id   = (r0 & r1) ? ~last : r1;
                    last = id;
                    dat  = id ? d1 : d0;
                    e[k].g[id] = 1'b1;
                    e[k].sdd   = {id, id ? ~dat : dat, id ? dat : ~dat};
                    e[k+3+S].ack = 1'b1;
                    e[k+3+S].ai  = id;
                    e[k+3+S].ad  = dat;
                    free_at = k + 4 + S;
                end
            end
            chk("rnd_pulse", 32'({bus.gnt1, bus.gnt0, bus.ack, bus.clr_done, bus.err, bus.dff_rst}),
                32'({e[k].g, e[k].ack, e[k].cd, 1'b0, e[k].dr}));
            if (e[k].ack) chk("rnd_ack", 32'({bus.ack_id, bus.ack_data}), 32'({e[k].ai, e[k].ad}));
            if (e[k].g != 2'b00)
                chk("rnd_legs", 32'({bus.dff_sel, bus.dff_d0, bus.dff_d1}), 32'(e[k].sdd));
            if (e[k].g[0]) r0 = 1'b0;
            if (e[k].g[1]) r1 = 1'b0;
            if (e[k].cd)   cr = 1'b0;
            if (!r0 && ($urandom % 4 == 0)) begin r0 = 1'b1; d0 = 1'($urandom); end
            else if (r0 && ($urandom % 32 == 0)) r0 = 1'b0;
            if (!r1 && ($urandom % 4 == 0)) begin r1 = 1'b1; d1 = 1'($urandom); end
            else if (r1 && ($urandom % 32 == 0)) r1 = 1'b0;
            if (!cr && ($urandom % 16 == 0)) cr = 1'b1;
            bus.req0 = r0; bus.data0 = d0; bus.req1 = r1; bus.data1 = d1; bus.clr_req = cr;
        end
        chk("rnd_errcnt", 32'(bus.err_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
